serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial full adder. Computes S = A + B + CIN over WIDTH bits, LSB-first, one full-adder bit per clock.
- The carry is held in a single flip-flop between bits.
- This block is the additive counterpart of the team's full-subtractor datapath. It reconstructs a minuend from a difference and a subtrahend, and it provides a low-area adder for small control datapaths.
- Interface is a start/busy/done handshake with registered operands and results.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- CLK   input   1      rising-edge clock
- RST   input   1      synchronous reset, active-high
- START input   1      request; sampled only in IDLE or FIN
- A     input   WIDTH  augend; sampled on the accepting edge only
- B     input   WIDTH  addend; sampled on the accepting edge only
- CIN   input   1      carry-in; sampled on the accepting edge only
- BUSY  output  1      high while an operation is in progress (RUN state)
- DONE  output  1      one-cycle pulse: S/COUT valid and newly updated
- S     output  WIDTH  sum, registered, held until the next completion
- COUT  output  1      carry-out, registered, held with S

Behaviour:
- One clock domain (CLK). RST is synchronous and active-high, and it overrides all other inputs.
- Reset values: state = IDLE, BUSY = 0, DONE = 0, S = 0, COUT = 0. Internal shift registers, carry flip-flop and bit counter are also cleared.
- FSM states are IDLE, RUN and FIN.
  - IDLE: START = 1 at an edge latches A, B and CIN into the internal operand shift registers and the carry flip-flop, clears the bit counter, and moves to RUN. START = 0 stays in IDLE.
  - RUN: at each edge, compute one full-adder bit.
    - sum = a_sh[0] ^ b_sh[0] ^ carry
    - carry <= majority(a_sh[0], b_sh[0], carry)
    - sum is shifted into the MSB of the internal result register.
    - a_sh and b_sh shift right by one.
    - The counter increments.
  - RUN exit: on the edge that processes bit WIDTH-1, copy the result register to S and the final carry to COUT, then go to FIN.
  - FIN: DONE = 1 for exactly this one cycle. START = 1 here is accepted exactly as in IDLE (back-to-back operation, goes to RUN). Otherwise go to IDLE.
- Timing, with START accepted at edge k:
  - BUSY = 1 from after edge k through edge k+WIDTH.
  - S and COUT update at edge k+WIDTH.
  - DONE = 1 during the cycle after edge k+WIDTH, with BUSY = 0 in that cycle.
  - Throughput is one result per WIDTH+1 cycles.
- START in RUN is ignored. Changes on A, B and CIN after the accepting edge have no effect.
- S and COUT change only at completion. They never show partial results and are stable at all other times, including during RUN of the next operation.
- Arithmetic: {COUT, S} = A + B + CIN, exact over WIDTH+1 bits, no saturation. Wrap-around shows only as COUT = 1.
- Bit counter width is clog2(WIDTH)+1. Terminal count is WIDTH-1.
- WIDTH = 1: RUN lasts one edge, so DONE appears 2 cycles after the accepting edge.
- RST during RUN aborts the operation:
  - Next state is IDLE.
  - S and COUT are cleared to 0.
  - No DONE pulse is issued.
  - START asserted together with RST is ignored.
- RST during FIN: DONE falls at that edge and the result is cleared.

Test Plan:
- Reset, then idle 5 cycles: BUSY = 0, DONE = 0, S = 0x00, COUT = 0 throughout.
- WIDTH = 8, A = 0x5A, B = 0x3C, CIN = 0, START pulse: BUSY high 8 cycles, then DONE pulses once with S = 0x96, COUT = 0.
- A = 0xFF, B = 0x01, CIN = 0 gives S = 0x00, COUT = 1. A = 0xFF, B = 0xFF, CIN = 1 gives S = 0xFF, COUT = 1. A = 0x00, B = 0x00, CIN = 1 gives S = 0x01, COUT = 0.
- Start A = 0x10, B = 0x20. Pulse START with A = 0xAA during RUN cycle 3: that START is ignored and the result is S = 0x30. Hold START high in FIN with A = 0x01, B = 0x02: the next result is S = 0x03, exactly 9 cycles after the first DONE.
- Start A = 0x7F, B = 0x7F. Assert RST at RUN cycle 4: state returns to IDLE, S = 0, COUT = 0, and no DONE pulse follows. A subsequent START with A = 0x01, B = 0x01 completes with S = 0x02.
- Exhaustive check at WIDTH = 1 over all 8 combinations of A, B and CIN: {COUT, S} matches the full-adder truth table, with DONE 2 cycles after each START.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial full adder, LSB first, one bit per clock
// Start/busy/done handshake; S and COUT only change on completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_shifted;

  always_comb begin
    sum_bit     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_nxt   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    // Written as shifts so that WIDTH = 1 needs no special-case slicing.
    res_shifted = (res_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = CIN;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = carry_nxt;
        res_d   = res_shifted;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          s_d     = res_shifted;
          cout_d  = carry_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign S    = s_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
// WIDTH = 8 instance for the main sequences, WIDTH = 1 instance for the truth table.
module tb_serial_adder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START, CIN;
  logic [7:0] A, B;
  logic       BUSY, DONE, COUT;
  logic [7:0] S;

  logic START1, A1, B1, CIN1;
  logic BUSY1, DONE1, S1, COUT1;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int done_cyc      = 0;
  int prev_done_cyc = 0;
  int held          = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .S(S), .COUT(COUT)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .A(A1), .B(B1), .CIN(CIN1),
    .BUSY(BUSY1), .DONE(DONE1), .S(S1), .COUT(COUT1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge CLK);
    A = a; B = b; CIN = cin; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom);
  endtask

  // Called just after the accepting edge; ends on the sampling point of the DONE cycle.
  task automatic track(input int exp, input int glitch);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("run_busy", int'(BUSY), 1);
      check("run_done", int'(DONE), 0);
      check("run_s_held", int'({COUT, S}), held);
      if (i == glitch) begin
        A = 8'hAA; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
      end else begin
        @(posedge CLK);
      end
    end
    @(negedge CLK);
    check("fin_done", int'(DONE), 1);
    check("fin_busy", int'(BUSY), 0);
    check("result", int'({COUT, S}), exp);
    held          = exp;
    prev_done_cyc = done_cyc;
    done_cyc      = cyc;
  endtask

  task automatic settle;
    @(negedge CLK);
    check("post_done", int'(DONE), 0);
    check("post_busy", int'(BUSY), 0);
    check("post_s_held", int'({COUT, S}), held);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    launch(a, b, cin);
    track(int'(a) + int'(b) + int'(cin), -1);
    settle();
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
    START1 = 1'b0; A1 = 1'b0; B1 = 1'b0; CIN1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("rst_busy", int'(BUSY), 0);
      check("rst_done", int'(DONE), 0);
      check("rst_sum", int'({COUT, S}), 0);
    end
    check("rst_w1", int'({BUSY1, DONE1, COUT1, S1}), 0);

    op(8'h5A, 8'h3C, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);
    op(8'h00, 8'h00, 1'b1);

    for (int n = 0; n < 20; n++)
      op(8'($urandom), 8'($urandom), 1'($urandom));

    // START during RUN is ignored; START held in FIN chains the next operation.
    launch(8'h10, 8'h20, 1'b0);
    track(32'h30, 2);
    A = 8'h01; B = 8'h02; CIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    track(32'h03, -1);
    check("b2b_gap", done_cyc - prev_done_cyc, 9);
    settle();

    // Reset in the middle of RUN aborts without a DONE pulse.
    launch(8'h7F, 8'h7F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abort_busy", int'(BUSY), 1);
      @(posedge CLK);
    end
    @(negedge CLK);
    RST = 1'b1; START = 1'b1; A = 8'h55; B = 8'h55;
    @(posedge CLK);
    #1 RST = 1'b0; START = 1'b0;
    held = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      check("abort_busy_lo", int'(BUSY), 0);
      check("abort_no_done", int'(DONE), 0);
      check("abort_sum", int'({COUT, S}), 0);
    end
    op(8'h01, 8'h01, 1'b0);

    for (int v = 0; v < 8; v++) begin
      int ones;
      ones = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
      @(negedge CLK);
      A1 = 1'(v >> 2); B1 = 1'(v >> 1); CIN1 = 1'(v); START1 = 1'b1;
      @(posedge CLK);
      #1 START1 = 1'b0;
      @(negedge CLK);
      check("w1_busy", int'(BUSY1), 1);
      check("w1_early_done", int'(DONE1), 0);
      @(posedge CLK);
      @(negedge CLK);
      check("w1_done", int'(DONE1), 1);
      check("w1_sum", int'({COUT1, S1}), (ones >= 2 ? 2 : 0) + (ones % 2));
      @(negedge CLK);
      check("w1_done_pulse", int'(DONE1), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
